// File: rtl/seg_scan_capture_if.sv
// Frame delivery port of the segment-scan capture block.
// Carries one decoded display frame from the capture logic (master) to
// its consumer (slave) using a valid/ready handshake.
//   frm_valid   master->slave  a complete frame is held on the bus
//   frm_ready   slave->master  consumer accepts the frame this cycle
//   frm_codes   master->slave  6-bit char code per digit, digit i at [6i+5:6i]
//   frm_raw     master->slave  raw 7-bit pattern per digit, digit i at [7i+6:7i]
//   frm_changed master->slave  codes differ from the last transferred frame
//   bad_char    master->slave  per-digit flag, pattern had no decode entry
//   overrun     master->slave  sticky, a frame was dropped while one was pending
interface seg_scan_capture_if #(
  parameter int DIGITS = 3
);
  logic                  frm_valid;
  logic                  frm_ready;
  logic [6*DIGITS-1:0]   frm_codes;
  logic [7*DIGITS-1:0]   frm_raw;
  logic                  frm_changed;
  logic [DIGITS-1:0]     bad_char;
  logic                  overrun;

  modport master (
    output frm_valid, frm_codes, frm_raw, frm_changed, bad_char, overrun,
    input  frm_ready
  );

  modport slave (
    input  frm_valid, frm_codes, frm_raw, frm_changed, bad_char, overrun,
    output frm_ready
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Receiving end of a multiplexed 7-segment display bus. The scanned
// segment and anode lines are synchronized and debounced. Each stable
// per-digit pattern is captured into a slot. A full set of slots is
// decoded to character codes and offered as one frame on the frm port.
//   clock    in   system clock, posedge
//   reset_1  in   asynchronous active-high reset
//   seg      in   segment lines, active-low, bit6=a .. bit0=g
//   bas      in   anode select, active-low, one digit low at a time
//   frm      --   frame output port (seg_scan_capture_if.master)
module seg_scan_capture #(
  parameter int DIGITS        = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset_1,
  input  logic [6:0]        seg,
  input  logic [DIGITS-1:0] bas,
  seg_scan_capture_if.master frm
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic {SYNC, CAPTURE} state_t;

  logic [6:0]          seg_s1, seg_s2, seg_prev;
  logic [DIGITS-1:0]   bas_s1, bas_s2, bas_prev;
  logic [CW-1:0]       stab_cnt;
  logic [DIGITS-1:0]   active;
  logic                one_low, same, accept;
  state_t              state, state_next;
  logic                clear_flags, write_slot, complete;
  logic [DIGITS-1:0]   flags;
  logic [6:0]          slot [DIGITS];
  logic [6:0]          dec;
  logic [6*DIGITS-1:0] new_codes, codes_q, last_codes, ref_codes;
  logic [7*DIGITS-1:0] new_raw, raw_q;
  logic [DIGITS-1:0]   new_bad, bad_q;
  logic                valid_q, changed_q, overrun_q, have_xfer, xfer, ref_ok;

  // Returns {bad, code}; unknown patterns give bad=1 and code 0x3F.
  function automatic logic [6:0] decode_seg(input logic [6:0] p);
    logic [6:0] r;
    case (p)
      7'b0000001: r = {1'b0, 6'h00};
      7'b1001111: r = {1'b0, 6'h01};
      7'b0010010: r = {1'b0, 6'h02};
      7'b0000110: r = {1'b0, 6'h03};
      7'b1001100: r = {1'b0, 6'h04};
      7'b0100100: r = {1'b0, 6'h05};
      7'b0100000: r = {1'b0, 6'h06};
      7'b0001111: r = {1'b0, 6'h07};
      7'b0000000: r = {1'b0, 6'h08};
      7'b0000100: r = {1'b0, 6'h09};
      7'b1111111: r = {1'b0, 6'h0A};
      7'b1111110: r = {1'b0, 6'h0B};
      7'b0001000: r = {1'b0, 6'h0C};
      7'b0110000: r = {1'b0, 6'h0D};
      7'b1001000: r = {1'b0, 6'h0E};
      7'b1111001: r = {1'b0, 6'h0F};
      7'b1110001: r = {1'b0, 6'h10};
      7'b1000011: r = {1'b0, 6'h11};
      7'b1000001: r = {1'b0, 6'h12};
      7'b1100010: r = {1'b0, 6'h13};
      default:    r = {1'b1, 6'h3F};
    endcase
    return r;
  endfunction

  // Two-flop synchronizers; idle value is all lines high (nothing lit).
  always_ff @(posedge clock or posedge reset_1) begin
    if (reset_1) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      bas_s1 <= '1;
      bas_s2 <= '1;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      bas_s1 <= bas;
      bas_s2 <= bas_s1;
    end
  end

  assign active  = ~bas_s2;
  assign one_low = (active != '0) && ((active & (active - DIGITS'(1))) == '0);
  assign same    = ({bas_s2, seg_s2} == {bas_prev, seg_prev});
  // Firing only on the step from STABLE_CYCLES-1 to STABLE_CYCLES gives one
  // accept per dwell; the counter saturates until the inputs change.
  assign accept  = same && (stab_cnt == CNT_ARM) && one_low;

  // Stability counter: restarts whenever the synchronized bus changes.
  always_ff @(posedge clock or posedge reset_1) begin
    if (reset_1) begin
      seg_prev <= '1;
      bas_prev <= '1;
      stab_cnt <= '0;
    end else begin
      seg_prev <= seg_s2;
      bas_prev <= bas_s2;
      if (!same) begin
        stab_cnt <= CW'(1);
      end else if (stab_cnt != CNT_MAX) begin
        stab_cnt <= stab_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset_1) begin
    if (reset_1) state <= SYNC;
    else         state <= state_next;
  end

  // Frame assembly: SYNC waits for digit 0, CAPTURE fills slots until every
  // flag is set, then spends one clock handing the frame to the output stage.
  always_comb begin
    state_next  = state;
    clear_flags = 1'b0;
    write_slot  = 1'b0;
    complete    = 1'b0;
    case (state)
      SYNC: begin
        if (accept && active[0]) begin
          write_slot  = 1'b1;
          clear_flags = 1'b1;
          state_next  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (&flags) begin
          complete    = 1'b1;
          clear_flags = 1'b1;
          state_next  = SYNC;
        end else if (accept) begin
          write_slot  = 1'b1;
          clear_flags = active[0];
        end
      end
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge clock or posedge reset_1) begin
    if (reset_1) begin
      flags <= '0;
      for (int i = 0; i < DIGITS; i++) slot[i] <= '1;
    end else begin
      flags <= (clear_flags ? '0 : flags) | (write_slot ? active : '0);
      for (int i = 0; i < DIGITS; i++) begin
        if (write_slot && active[i]) slot[i] <= seg_s2;
      end
    end
  end

  always_comb begin
    new_codes = '0;
    new_raw   = '0;
    new_bad   = '0;
    dec       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dec                = decode_seg(slot[i]);
      new_codes[6*i +: 6] = dec[5:0];
      new_bad[i]          = dec[6];
      new_raw[7*i +: 7]   = slot[i];
    end
  end

  // A frame transferring in the same cycle a new one loads is the reference
  // for the new frame's change flag.
  assign xfer      = valid_q && frm.frm_ready;
  assign ref_codes = xfer ? codes_q : last_codes;
  assign ref_ok    = xfer || have_xfer;

  // Output holding register: loads only when empty or being emptied this
  // cycle; otherwise the completed frame is dropped and overrun latches.
  always_ff @(posedge clock or posedge reset_1) begin
    if (reset_1) begin
      valid_q    <= 1'b0;
      codes_q    <= {DIGITS{6'h0A}};
      raw_q      <= '1;
      bad_q      <= '0;
      changed_q  <= 1'b0;
      overrun_q  <= 1'b0;
      last_codes <= '0;
      have_xfer  <= 1'b0;
    end else begin
      if (complete) begin
        if (!valid_q || xfer) begin
          valid_q   <= 1'b1;
          codes_q   <= new_codes;
          raw_q     <= new_raw;
          bad_q     <= new_bad;
          changed_q <= !ref_ok || (new_codes != ref_codes);
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
      if (xfer) begin
        last_codes <= codes_q;
        have_xfer  <= 1'b1;
      end
    end
  end

  assign frm.frm_valid   = valid_q;
  assign frm.frm_codes   = codes_q;
  assign frm.frm_raw     = raw_q;
  assign frm.frm_changed = changed_q;
  assign frm.bad_char    = bad_q;
  assign frm.overrun     = overrun_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed handshake/reset
// sequences, a table of frame vectors, and randomized scanning checked
// against a frame-level reference model.
module tb_seg_scan_capture;
  localparam int DIGITS = 3;
  localparam int STABLE = 4;

  localparam logic [6:0] P_0 = 7'b0000001, P_1 = 7'b1001111, P_2 = 7'b0010010;
  localparam logic [6:0] P_3 = 7'b0000110, P_DASH = 7'b1111110, P_A = 7'b0001000;
  localparam logic [6:0] P_E = 7'b0110000, P_H = 7'b1001000, P_I = 7'b1111001;
  localparam logic [6:0] P_L = 7'b1110001, P_J = 7'b1000011, P_U = 7'b1000001;
  localparam logic [6:0] P_O = 7'b1100010, P_BAD = 7'b0101010, P_BLANK = 7'b1111111;

  logic              clock = 1'b0;
  logic              reset_1;
  logic [6:0]        seg;
  logic [DIGITS-1:0] bas;

  seg_scan_capture_if #(.DIGITS(DIGITS)) frm_if ();

  seg_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clock   (clock),
    .reset_1 (reset_1),
    .seg     (seg),
    .bas     (bas),
    .frm     (frm_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [17:0] codes;
    logic [20:0] raw;
    logic [2:0]  bad;
    logic        changed;
  } frame_t;

  typedef struct {
    logic [6:0]  s0, s1, s2;
    logic [17:0] codes;
    logic [2:0]  bad;
    logic        changed;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          valid_seen = 0;
  logic        mon_en = 1'b0;
  frame_t      exp_q[$];
  frame_t      mon_f;
  logic [2:0]  last_b = '1;
  logic [6:0]  last_s = '1;

  // Character table: index is the character code.
  logic [6:0] pat_tab [20] = '{P_0, P_1, P_2, P_3, 7'b1001100, 7'b0100100,
                               7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                               P_BLANK, P_DASH, P_A, P_E, P_H, P_I, P_L, P_J,
                               P_U, P_O};

  // Reference model state: frame-level view of accepted digits.
  logic        model_on = 1'b0;
  logic        m_cap;
  logic [2:0]  m_got;
  logic [6:0]  m_slot [3];
  logic [17:0] m_prev;
  logic        m_prev_ok;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [6:0] model_code(input logic [6:0] p);
    for (int i = 0; i < 20; i++) begin
      if (pat_tab[i] == p) return {1'b0, 6'(i)};
    end
    return {1'b1, 6'h3F};
  endfunction

  function automatic bit is_one_low(input logic [2:0] b);
    return $countones(~b) == 1;
  endfunction

  function automatic int digit_of(input logic [2:0] b);
    for (int i = 0; i < 3; i++) if (!b[i]) return i;
    return 0;
  endfunction

  task automatic model_accept(input int d, input logic [6:0] p);
    frame_t     f;
    logic [6:0] dc;
    if (!m_cap) begin
      if (d == 0) begin
        m_cap = 1'b1;
        m_got = 3'b001;
        m_slot[0] = p;
      end
    end else begin
      if (d == 0) m_got = '0;
      m_got[d] = 1'b1;
      m_slot[d] = p;
      if (m_got == 3'b111) begin
        for (int i = 0; i < 3; i++) begin
          dc = model_code(m_slot[i]);
          f.codes[6*i +: 6] = dc[5:0];
          f.bad[i] = dc[6];
          f.raw[7*i +: 7] = m_slot[i];
        end
        f.changed = !m_prev_ok || (f.codes != m_prev);
        m_prev = f.codes;
        m_prev_ok = 1'b1;
        exp_q.push_back(f);
        m_cap = 1'b0;
        m_got = '0;
      end
    end
  endtask

  // Drives one bus value for dur clocks; called on a negedge.
  task automatic applyStimulus(input logic [2:0] b, input logic [6:0] s, input int dur);
    bas = b;
    seg = s;
    last_b = b;
    last_s = s;
    if (model_on && dur >= STABLE && is_one_low(b)) model_accept(digit_of(b), s);
    repeat (dur) @(negedge clock);
  endtask

  task automatic scanFrame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input int dur);
    applyStimulus(3'b110, s0, dur);
    applyStimulus(3'b101, s1, dur);
    applyStimulus(3'b011, s2, dur);
  endtask

  task automatic waitValid(input int maxc, output int cyc);
    cyc = 0;
    while (!frm_if.frm_valid && cyc < maxc) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("valid_timeout", 32'(frm_if.frm_valid), 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    logic [17:0] blank_codes;
    blank_codes = {3{6'h0A}};
    checkOutput({tag, "_valid"},   32'(frm_if.frm_valid),   32'd0);
    checkOutput({tag, "_codes"},   32'(frm_if.frm_codes),   32'(blank_codes));
    checkOutput({tag, "_raw"},     32'(frm_if.frm_raw),     32'h1FFFFF);
    checkOutput({tag, "_changed"}, 32'(frm_if.frm_changed), 32'd0);
    checkOutput({tag, "_bad"},     32'(frm_if.bad_char),    32'd0);
    checkOutput({tag, "_overrun"}, 32'(frm_if.overrun),     32'd0);
  endtask

  // Frame monitor: every handshake must match the next expected frame.
  always @(negedge clock) begin
    if (frm_if.frm_valid) valid_seen++;
    if (mon_en && frm_if.frm_valid && frm_if.frm_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_frame", 32'(frm_if.frm_valid), 32'd0);
      end else begin
        mon_f = exp_q.pop_front();
        checkOutput("mon_codes",   32'(frm_if.frm_codes),   32'(mon_f.codes));
        checkOutput("mon_raw",     32'(frm_if.frm_raw),     32'(mon_f.raw));
        checkOutput("mon_bad",     32'(frm_if.bad_char),    32'(mon_f.bad));
        checkOutput("mon_changed", 32'(frm_if.frm_changed), 32'(mon_f.changed));
      end
    end
  end

  initial begin
    vec_t        tbl [5];
    frame_t      f;
    int          cyc;
    int          last_digit;
    logic [17:0] hai_codes;
    logic [2:0]  b;
    logic [6:0]  s;
    int          dur;
    int          r;
    logic [2:0]  bad_bas [5];

    hai_codes = {6'h0F, 6'h0C, 6'h0E};
    tbl[0] = '{P_H, P_A, P_I, hai_codes, 3'b000, 1'b1};
    tbl[1] = '{P_H, P_A, P_I, hai_codes, 3'b000, 1'b0};
    tbl[2] = '{P_0, P_DASH, P_2, {6'h02, 6'h0B, 6'h00}, 3'b000, 1'b1};
    tbl[3] = '{P_E, P_BAD, P_U, {6'h12, 6'h3F, 6'h0D}, 3'b010, 1'b1};
    tbl[4] = '{P_H, P_A, P_I, hai_codes, 3'b000, 1'b1};
    bad_bas = '{3'b111, 3'b000, 3'b001, 3'b010, 3'b100};

    reset_1 = 1'b1;
    bas = '1;
    seg = '1;
    frm_if.frm_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset_1 = 1'b0;
    checkResetState("reset");

    // First frame with consumer stalled: latency, contents, then overrun.
    applyStimulus(3'b110, P_H, 8);
    applyStimulus(3'b101, P_A, 8);
    bas = 3'b011;
    seg = P_I;
    waitValid(20, cyc);
    checkOutput("latency", 32'(cyc), 32'(2 + STABLE + 1));
    repeat (2) @(negedge clock);
    checkOutput("t1_codes",   32'(frm_if.frm_codes),   32'(hai_codes));
    checkOutput("t1_raw",     32'(frm_if.frm_raw),     32'({P_I, P_A, P_H}));
    checkOutput("t1_changed", 32'(frm_if.frm_changed), 32'd1);
    checkOutput("t1_bad",     32'(frm_if.bad_char),    32'd0);
    checkOutput("t1_overrun", 32'(frm_if.overrun),     32'd0);
    scanFrame(P_1, P_2, P_3, 8);
    checkOutput("t4_valid",   32'(frm_if.frm_valid),   32'd1);
    checkOutput("t4_codes",   32'(frm_if.frm_codes),   32'(hai_codes));
    checkOutput("t4_raw",     32'(frm_if.frm_raw),     32'({P_I, P_A, P_H}));
    checkOutput("t4_overrun", 32'(frm_if.overrun),     32'd1);
    frm_if.frm_ready = 1'b1;
    @(negedge clock);
    checkOutput("t4_valid_drop", 32'(frm_if.frm_valid), 32'd0);
    checkOutput("t4_sticky",     32'(frm_if.overrun),   32'd1);
    frm_if.frm_ready = 1'b0;

    // Reset in the middle of a frame, then one clean frame.
    applyStimulus(3'b110, P_L, 8);
    applyStimulus(3'b101, P_J, 8);
    reset_1 = 1'b1;
    @(negedge clock);
    reset_1 = 1'b0;
    checkResetState("midreset");
    scanFrame(P_L, P_J, P_O, 8);
    waitValid(20, cyc);
    checkOutput("t6_codes",   32'(frm_if.frm_codes),   32'({6'h13, 6'h11, 6'h10}));
    checkOutput("t6_changed", 32'(frm_if.frm_changed), 32'd1);
    checkOutput("t6_bad",     32'(frm_if.bad_char),    32'd0);
    frm_if.frm_ready = 1'b1;
    @(negedge clock);
    checkOutput("t6_valid_drop", 32'(frm_if.frm_valid), 32'd0);

    // Short dwells and mid-dwell glitches must never produce a frame.
    valid_seen = 0;
    for (int k = 0; k < 2; k++) scanFrame(P_H, P_A, P_I, 3);
    for (int d = 0; d < 3; d++) begin
      b = ~(3'b001 << d);
      applyStimulus(b, P_E, 3);
      applyStimulus(b, P_E ^ 7'b0001000, 1);
      applyStimulus(b, P_E, 3);
    end
    applyStimulus(3'b111, P_BLANK, 10);
    checkOutput("t3_no_frame", 32'(valid_seen), 32'd0);

    // Table-driven frames with the consumer always ready.
    mon_en = 1'b1;
    for (int v = 0; v < 5; v++) begin
      f.codes   = tbl[v].codes;
      f.raw     = {tbl[v].s2, tbl[v].s1, tbl[v].s0};
      f.bad     = tbl[v].bad;
      f.changed = tbl[v].changed;
      exp_q.push_back(f);
      scanFrame(tbl[v].s0, tbl[v].s1, tbl[v].s2, 8);
    end
    applyStimulus(3'b111, P_BLANK, 10);
    checkOutput("table_drain", 32'(exp_q.size()), 32'd0);

    // Randomized scanning against the reference model.
    model_on  = 1'b1;
    m_cap     = 1'b0;
    m_got     = '0;
    m_prev    = hai_codes;
    m_prev_ok = 1'b1;
    last_digit = 2;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        last_digit = (last_digit + 1) % 3;
        b = ~(3'b001 << last_digit);
      end else if (r == 7) begin
        last_digit = $urandom_range(0, 2);
        b = ~(3'b001 << last_digit);
      end else begin
        b = bad_bas[$urandom_range(0, 4)];
      end
      if ($urandom_range(0, 4) != 0) s = pat_tab[$urandom_range(0, 19)];
      else                           s = 7'($urandom);
      if ({b, s} == {last_b, last_s}) s[0] = ~s[0];
      dur = ($urandom_range(0, 3) != 0) ? $urandom_range(8, 11) : $urandom_range(2, 3);
      applyStimulus(b, s, dur);
    end
    model_on = 1'b0;
    applyStimulus(3'b111, (last_s == P_BLANK) ? P_0 : P_BLANK, 20);
    checkOutput("random_drain",   32'(exp_q.size()),     32'd0);
    checkOutput("random_overrun", 32'(frm_if.overrun),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
